// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and dmem_responder.
// master = initiator side, slave = responder side.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data memory responder: byte/half/word loads and stores,
// fixed access latency, misalignment detection and load sign/zero extension.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// ACCESS | request held, wait counter running; commit on terminal count
// RESP   | resp_valid high, outputs held until resp_ready
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic clock,
  input  logic reset,
  dmem_responder_if.slave bus
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [3:0]    wait_cnt;
  logic          accept;
  logic          commit;
  logic          resp_done;

  logic          hold_write;
  logic [1:0]    hold_size;
  logic          hold_unsigned;
  logic [AW+1:0] hold_addr;
  logic [31:0]   hold_wdata;

  logic [AW-1:0] hold_idx;
  logic          hold_err;
  logic [3:0]    lane_en;
  logic [31:0]   wlanes;
  logic [31:0]   mem_word;
  logic [31:0]   shifted;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  logic [31:0]   resp_rdata_q;
  logic          resp_err_q;

  logic [31:0]   mem [DEPTH_WORDS];

  // Address bits above the word index alias onto the same storage.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:AW+2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    accept         = 1'b0;
    commit         = 1'b0;
    resp_done      = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept   = 1'b1;
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_cnt == 4'd0) begin
          commit   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          resp_done = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Down-counter loaded at accept; terminal count 0 marks the commit edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (accept) begin
      wait_cnt <= WAIT_LOAD;
    end else if (state == ACCESS && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_write    <= 1'b0;
      hold_size     <= 2'b00;
      hold_unsigned <= 1'b0;
      hold_addr     <= '0;
      hold_wdata    <= '0;
    end else if (accept) begin
      hold_write    <= bus.req_write;
      hold_size     <= bus.req_size;
      hold_unsigned <= bus.req_unsigned;
      hold_addr     <= bus.req_addr[AW+1:0];
      hold_wdata    <= bus.req_wdata;
    end
  end

  assign hold_idx = hold_addr[AW+1:2];

  always_comb begin
    hold_err = 1'b0;
    lane_en  = 4'b0000;
    wlanes   = hold_wdata;
    case (hold_size)
      2'b00: begin
        lane_en = 4'b0001 << hold_addr[1:0];
        wlanes  = {4{hold_wdata[7:0]}};
      end
      2'b01: begin
        hold_err = hold_addr[0];
        lane_en  = hold_addr[1] ? 4'b1100 : 4'b0011;
        wlanes   = {2{hold_wdata[15:0]}};
      end
      2'b10: begin
        hold_err = (hold_addr[1:0] != 2'b00);
        lane_en  = 4'b1111;
      end
      default: hold_err = 1'b1;
    endcase
  end

  assign mem_word = mem[hold_idx];
  assign shifted  = mem_word >> {hold_addr[1:0], 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = hold_addr[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    load_ext = mem_word;
    case (hold_size)
      2'b00:   load_ext = {{24{~hold_unsigned & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~hold_unsigned & half_sel[15]}}, half_sel};
      default: load_ext = mem_word;
    endcase
  end

  // No reset here: storage survives reset, and reset forces state to IDLE so
  // an interrupted store never reaches its commit edge.
  always_ff @(posedge clock) begin
    if (commit && hold_write && !hold_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[hold_idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else if (commit) begin
      resp_err_q   <= hold_err;
      resp_rdata_q <= (hold_err || hold_write) ? 32'd0 : load_ext;
    end else if (resp_done) begin
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end
  end

  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule
